// File: rtl/dff_serial_capture_pkg.sv
// Shared types and helpers for the serial capture block.
`timescale 1ns/100ps
package dff_serial_capture_pkg;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_SHIFT = 1'b1
  } cap_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/dff_serial_capture_if.sv
// Serial-in / word-out bus of the capture block.
`timescale 1ns/100ps
interface dff_serial_capture_if #(parameter int WIDTH = 8);
  logic             d_in;
  logic             d_valid;
  logic             frame_start;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             busy;

  modport master (output d_in, d_valid, frame_start, out_ready,
                  input  out_data, out_valid, overrun, busy);
  modport slave  (input  d_in, d_valid, frame_start, out_ready,
                  output out_data, out_valid, overrun, busy);
endinterface

// File: rtl/dff_serial_capture_bit_counter.sv
// Bit position counter; pulses last on the WIDTH-th accepted bit and wraps.
`timescale 1ns/100ps
module capture_bit_counter
  import dff_serial_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = inc && !clear && (count == CW'(WIDTH-1));

  // clear together with inc re-aligns: the current bit is bit 0
  always_ff @(posedge clk) begin
    if (!reset_n)   count <= '0;
    else if (clear) count <= inc ? CW'(1) : '0;
    else if (inc)   count <= last ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/dff_serial_capture.sv
// Frame-aligned serial-to-parallel capture with one-word buffer and sticky overrun.
// Build option: CAPTURE_GATE_DELAY_EN adds gate-model delays on the outputs.
`timescale 1ns/100ps
module dff_serial_capture
  import dff_serial_capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 reset_n,
  dff_serial_capture_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_nxt;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q, overrun_q;
  logic [CW-1:0]    bit_cnt;
  logic             align, accept, last, word_done, can_load;

  assign align     = bus.d_valid && bus.frame_start;
  assign accept    = bus.d_valid && (state_q == CAP_SHIFT || bus.frame_start);
  assign word_done = accept && last;
  assign can_load  = !out_valid_q || bus.out_ready;

  capture_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (align),
    .inc    (accept),
    .count  (bit_cnt),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= CAP_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sr_nxt  = sr_q;
    if (align) state_d = CAP_SHIFT;
    if (align)
      sr_nxt = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.d_in} : {bus.d_in, {(WIDTH-1){1'b0}}};
    else if (accept)
      sr_nxt = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.d_in} : {bus.d_in, sr_q[WIDTH-1:1]};
  end

  // a word finishing into a full, stalled buffer is dropped and flagged
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sr_q <= sr_nxt;
      if (word_done && can_load) begin
        out_data_q  <= sr_nxt;
        out_valid_q <= 1'b1;
      end else begin
        if (word_done)                     overrun_q   <= 1'b1;
        if (out_valid_q && bus.out_ready)  out_valid_q <= 1'b0;
      end
    end
  end

  cnt_range_a: assert property (@(posedge clk) disable iff (!reset_n) bit_cnt < CW'(WIDTH));

`ifdef CAPTURE_GATE_DELAY_EN
  `ifndef PRIMARY_OUT
    `define PRIMARY_OUT 1
  `endif
  `ifndef FAN_OUT_1
    `define FAN_OUT_1 1
  `endif
  assign #(`PRIMARY_OUT + `FAN_OUT_1) bus.out_data  = out_data_q;
  assign #(`PRIMARY_OUT + `FAN_OUT_1) bus.out_valid = out_valid_q;
  assign #(`PRIMARY_OUT + `FAN_OUT_1) bus.overrun   = overrun_q;
  assign #(`PRIMARY_OUT + `FAN_OUT_1) bus.busy      = (state_q == CAP_SHIFT);
`else
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q == CAP_SHIFT);
`endif

endmodule
